// File: rtl/ysyx_23060061_regfile_mp.sv
// rtl/ysyx_23060061_regfile_mp.sv - multi-port register file with write bypass and busy scoreboard
module ysyx_23060061_regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 2,
    parameter int NW         = 2,
    parameter int ZERO_REG0  = 1,
    parameter int BYPASS     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NW-1:0]              wen,
    input  logic [NW*ADDR_WIDTH-1:0]   waddr,
    input  logic [NW*DATA_WIDTH-1:0]   wdata,
    input  logic [NR*ADDR_WIDTH-1:0]   raddr,
    output logic [NR*DATA_WIDTH-1:0]   rdata,
    output logic [NR-1:0]              rbusy,
    input  logic                       rsv_en,
    input  logic [ADDR_WIDTH-1:0]      rsv_addr,
    output logic                       busy_any
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DATA_WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG0 != 0) && (a == '0);
    endfunction

    // Ascending port order lets the highest enabled port win a same-index conflict.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int k = 0; k < NW; k++) begin
            if (wen[k] && !is_zero_reg(waddr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rf_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]]   = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                busy_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        // Reserve applied last so a new issue beats a same-cycle completion.
        if (rsv_en && !is_zero_reg(rsv_addr)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  hit;
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NR; j++) begin
            ra  = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            rd  = rf_q[ra];
            hit = 1'b0;
            for (int k = 0; k < NW; k++) begin
                if ((BYPASS != 0) && wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    rd  = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                    hit = 1'b1;
                end
            end
            // Outputs are forced quiet while reset is held, even if writes are presented.
            if (!rst || is_zero_reg(ra)) begin
                rd = '0;
                rbusy[j] = 1'b0;
            end else begin
                rbusy[j] = busy_q[ra] & ~hit;
            end
            rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd;
        end
    end

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_ysyx_23060061_regfile_mp.sv
// tb/tb_ysyx_23060061_regfile_mp.sv - randomized model-checked bench for the multi-port register file
module tb_ysyx_23060061_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NW-1:0]       wen;
    logic [NW*AW-1:0]    waddr;
    logic [NW*DW-1:0]    wdata;
    logic [NR*AW-1:0]    raddr;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NR*DW-1:0]    rdata_v [2];
    logic [NR-1:0]       rbusy_v [2];
    logic                busy_any_v [2];

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    // Model state: index 0 = bypass + zero reg, index 1 = no bypass, ordinary reg 0.
    logic [DW-1:0] m_rf [2][DEPTH];
    logic          m_busy [2][DEPTH];
    bit            cfg_byp [2] = '{1'b1, 1'b0};
    bit            cfg_zr  [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    ysyx_23060061_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW),
                               .ZERO_REG0(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_v[0]), .rbusy(rbusy_v[0]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_any(busy_any_v[0]));

    ysyx_23060061_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW),
                               .ZERO_REG0(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_v[1]), .rbusy(rbusy_v[1]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_any(busy_any_v[1]));

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] wa(input int k);
        return waddr[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] rd_of(input int d, input int j);
        return rdata_v[d][j*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input int d, input logic [AW-1:0] a);
        if (cfg_zr[d] && a == 0) return '0;
        if (cfg_byp[d])
            for (int k = NW - 1; k >= 0; k--)
                if (wen[k] && wa(k) == a) return wdata[k*DW +: DW];
        return m_rf[d][a];
    endfunction

    function automatic logic exp_rbusy(input int d, input logic [AW-1:0] a);
        if (cfg_zr[d] && a == 0) return 1'b0;
        if (cfg_byp[d])
            for (int k = 0; k < NW; k++)
                if (wen[k] && wa(k) == a) return 1'b0;
        return m_busy[d][a];
    endfunction

    function automatic logic exp_busy_any(input int d);
        for (int r = 0; r < DEPTH; r++) if (m_busy[d][r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < DEPTH; r++) begin
                m_rf[d][r]   = '0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    // Each register takes the data of the highest enabled port naming it; reserve overrides release.
    task automatic model_update();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < DEPTH; r++) begin
                if (cfg_zr[d] && r == 0) continue;
                for (int k = NW - 1; k >= 0; k--)
                    if (wen[k] && int'(wa(k)) == r) begin
                        m_rf[d][r]   = wdata[k*DW +: DW];
                        m_busy[d][r] = 1'b0;
                        break;
                    end
                if (rsv_en && int'(rsv_addr) == r) m_busy[d][r] = 1'b1;
            end
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0; raddr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
        #1;
    endtask

    task automatic set_w(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v);
        wen[k] = 1'b1;
        waddr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = v;
    endtask

    task automatic set_r(input int j, input logic [AW-1:0] a);
        raddr[j*AW +: AW] = a;
    endtask

    task automatic mid_cycle_reset(input string name);
        cmp_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < NR; j++) chk({name, "_rdata"}, rd_of(d, j), '0);
            chk({name, "_rbusy"}, {28'd0, rbusy_v[d]}, '0);
            chk({name, "_busy_any"}, {31'd0, busy_any_v[d]}, '0);
        end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
        cmp_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int j = 0; j < NR; j++) begin
                    chk($sformatf("model_rdata_d%0d_p%0d", d, j), rd_of(d, j),
                        exp_rdata(d, raddr[j*AW +: AW]));
                    chk($sformatf("model_rbusy_d%0d_p%0d", d, j), {31'd0, rbusy_v[d][j]},
                        {31'd0, exp_rbusy(d, raddr[j*AW +: AW])});
                end
                chk($sformatf("model_busy_any_d%0d", d), {31'd0, busy_any_v[d]},
                    {31'd0, exp_busy_any(d)});
            end
        end
    end

    initial begin
        idle();
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < NR; j++) chk("reset_rdata", rd_of(0, j), '0);
        chk("reset_busy_any", {31'd0, busy_any_v[0]}, '0);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Asynchronous reset wipes a freshly written register.
        set_w(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle(); set_r(0, 5'd5);
        #1 chk("r5_written", rd_of(0, 0), 32'hDEAD_BEEF);
        mid_cycle_reset("async_rst");
        set_r(0, 5'd5);
        #1 chk("r5_after_rst", rd_of(0, 0), '0);

        // Dual write to distinct registers, then both ports to one register.
        set_w(0, 5'd3, 32'h11); set_w(1, 5'd4, 32'h22);
        tick();
        idle();
        set_w(0, 5'd7, 32'hAA); set_w(1, 5'd7, 32'hBB);
        set_r(0, 5'd3); set_r(1, 5'd4); set_r(2, 5'd7);
        #1;
        chk("dual_r3", rd_of(0, 0), 32'h11);
        chk("dual_r4", rd_of(0, 1), 32'h22);
        chk("conflict_bypass_r7", rd_of(0, 2), 32'hBB);
        tick();
        idle(); set_r(0, 5'd7);
        #1 chk("conflict_r7", rd_of(1, 0), 32'hBB);

        // Bypass versus stored value.
        set_w(0, 5'd9, 32'h1234); set_r(0, 5'd9);
        #1;
        chk("bypass_on", rd_of(0, 0), 32'h1234);
        chk("bypass_off", rd_of(1, 0), 32'h0);
        tick();

        // Register 0 behaviour.
        idle();
        set_w(0, 5'd0, 32'hFFFF_FFFF); rsv_en = 1'b1; rsv_addr = 5'd0; set_r(0, 5'd0);
        #1 chk("zero_rdata_bypass", rd_of(0, 0), '0);
        tick();
        idle(); set_r(0, 5'd0);
        #1;
        chk("zero_rdata", rd_of(0, 0), '0);
        chk("zero_rbusy", {31'd0, rbusy_v[0][0]}, '0);
        chk("zero_busy_any", {31'd0, busy_any_v[0]}, '0);
        chk("plain_r0_rdata", rd_of(1, 0), 32'hFFFF_FFFF);
        chk("plain_r0_busy_any", {31'd0, busy_any_v[1]}, 32'd1);
        set_w(0, 5'd0, 32'h0);
        tick();

        // Scoreboard reserve / release / reserve-beats-release.
        idle(); rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle(); set_r(0, 5'd6);
        #1 chk("sb_reserved", {31'd0, rbusy_v[0][0]}, 32'd1);
        set_w(0, 5'd6, 32'h66);
        #1;
        chk("sb_bypass_clear", {31'd0, rbusy_v[0][0]}, '0);
        chk("sb_nobypass_busy", {31'd0, rbusy_v[1][0]}, 32'd1);
        tick();
        idle(); set_r(0, 5'd6);
        #1;
        chk("sb_released", {31'd0, rbusy_v[0][0]}, '0);
        chk("sb_released_any", {31'd0, busy_any_v[0]}, '0);
        set_w(0, 5'd6, 32'h67); rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle(); set_r(0, 5'd6);
        #1 chk("sb_rsv_wins", {31'd0, rbusy_v[0][0]}, 32'd1);
        tick();

        // Random sweep, narrow address range half the time to provoke conflicts.
        for (int c = 0; c < 10000; c++) begin
            idle();
            for (int k = 0; k < NW; k++) begin
                wen[k] = ($urandom_range(0, 99) < 60);
                waddr[k*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                                  : AW'($urandom_range(0, 31));
                wdata[k*DW +: DW] = $urandom;
            end
            for (int j = 0; j < NR; j++)
                raddr[j*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                                  : AW'($urandom_range(0, 31));
            rsv_en   = ($urandom_range(0, 99) < 40);
            rsv_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                   : AW'($urandom_range(0, 31));
            if (c == 5000) mid_cycle_reset("sweep_rst");
            else tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
